// File: rtl/rom_loader_router_if.sv
// ioctl download stream from hps_io into the ROM loader router.
//
// Protocol: ioctl_wr is a one-cycle write strobe with no back-pressure.
// ioctl_addr, ioctl_dout and ioctl_index are valid in the cycle ioctl_wr is
// high. ioctl_download is a level that stays high for the whole transfer.
//
// Signals:
//   ioctl_download  download-active level
//   ioctl_wr        byte strobe
//   ioctl_addr[24:0] byte address
//   ioctl_dout[7:0] byte data
//   ioctl_index[7:0] download index (selects ROM / mod / DIP)
//
// Modports: master = stream source (hps_io), slave = router.
interface rom_loader_router_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
  );

  modport slave (
    input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
  );
endinterface

// File: rtl/rom_loader_router.sv
// ROM download router for arcade cores.
//
// Decodes each ROM-download byte into one of NUM_REGIONS address windows and
// issues a registered one-hot write strobe with the window-relative address.
// Captures the mod-select byte and up to eight DIP bytes. Holds the core in
// reset until a complete ROM image has arrived plus HOLD_CYCLES, and reports
// byte count, 16-bit checksum and a sticky region-miss flag.
//
// Ports:
//   clk_sys          clock
//   reset            synchronous active-high reset (top-level RESET only)
//   ioctl            download stream (slave side)
//   rgn_we           one-hot region write strobe, 1 cycle after the byte
//   rgn_addr         offset within the selected region
//   rgn_data         write data
//   mod_id/mod_valid last captured mod byte / captured since reset
//   dip_sw           DIP bytes, byte k at [8k+7:8k]
//   core_reset_hold  high until the FSM reaches DONE
//   load_done        high only in DONE
//   load_error       sticky: a ROM byte matched no region
//   byte_count       ROM bytes in the current/last download
//   checksum         sum mod 2^16 of ROM bytes in the current/last download
//   fsm_state        current FSM state (IDLE=0, LOADING=1, DRAIN=2, DONE=3)
module rom_loader_router #(
  parameter int                        NUM_REGIONS = 4,
  parameter int                        MAX_AW      = 16,
  parameter logic [NUM_REGIONS*25-1:0] REGION_BASE = {25'h0FF00, 25'h0E000, 25'h08000, 25'h00000},
  parameter logic [NUM_REGIONS*5-1:0]  REGION_AW   = {5'd16, 5'd12, 5'd12, 5'd15},
  parameter logic [7:0]                ROM_INDEX   = 8'd0,
  parameter logic [7:0]                MOD_INDEX   = 8'd1,
  parameter logic [7:0]                DIP_INDEX   = 8'd254,
  parameter int                        HOLD_CYCLES = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  rom_loader_router_if.slave     ioctl,
  output logic [NUM_REGIONS-1:0] rgn_we,
  output logic [MAX_AW-1:0]      rgn_addr,
  output logic [7:0]             rgn_data,
  output logic [7:0]             mod_id,
  output logic                   mod_valid,
  output logic [63:0]            dip_sw,
  output logic                   core_reset_hold,
  output logic                   load_done,
  output logic                   load_error,
  output logic [24:0]            byte_count,
  output logic [15:0]            checksum,
  output logic [1:0]             fsm_state
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOADING = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                 state;
  logic [CW-1:0]          drain_cnt;
  logic                   is_rom_idx;
  logic                   start;
  logic                   rom_byte;
  logic                   hit;
  logic [NUM_REGIONS-1:0] sel_we;
  logic [MAX_AW-1:0]      sel_off;
  logic [24:0]            win_off;

  assign fsm_state  = state;
  assign is_rom_idx = (ioctl.ioctl_index == ROM_INDEX);
  // A download start is taken from IDLE or DONE; DRAIN ignores it until DONE.
  assign start      = ((state == IDLE) || (state == DONE)) && ioctl.ioctl_download && is_rom_idx;
  // The byte on the start cycle itself belongs to the new download.
  assign rom_byte   = ioctl.ioctl_wr && is_rom_idx && ((state == LOADING) || start);
  assign hit        = |sel_we;

  // Window match: addr >= base and (addr - base) < 2^aw. Checking the
  // offset's upper bits avoids a 26-bit base+size sum. Scanning from the
  // highest index down lets the lowest matching index overwrite last.
  always_comb begin
    sel_we  = '0;
    sel_off = '0;
    win_off = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      win_off = ioctl.ioctl_addr - REGION_BASE[25*i +: 25];
      if ((ioctl.ioctl_addr >= REGION_BASE[25*i +: 25]) &&
          ((win_off >> REGION_AW[5*i +: 5]) == 25'd0)) begin
        sel_we    = '0;
        sel_we[i] = 1'b1;
        sel_off   = win_off[MAX_AW-1:0];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state           <= IDLE;
      drain_cnt       <= '0;
      rgn_we          <= '0;
      rgn_addr        <= '0;
      rgn_data        <= '0;
      mod_id          <= '0;
      mod_valid       <= 1'b0;
      dip_sw          <= '0;
      core_reset_hold <= 1'b1;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
      byte_count      <= '0;
      checksum        <= '0;
    end else begin
      // Write path
      rgn_we <= rom_byte ? sel_we : '0;
      if (rom_byte && hit) begin
        rgn_addr <= sel_off;
        rgn_data <= ioctl.ioctl_dout;
      end

      // Statistics restart on the start cycle, including that cycle's byte
      if (start) begin
        byte_count <= rom_byte ? 25'd1 : 25'd0;
        checksum   <= rom_byte ? {8'd0, ioctl.ioctl_dout} : 16'd0;
        load_error <= rom_byte && !hit;
      end else if (rom_byte) begin
        byte_count <= byte_count + 25'd1;
        checksum   <= checksum + {8'd0, ioctl.ioctl_dout};
        if (!hit) load_error <= 1'b1;
      end

      // Side-band bytes, accepted in any state
      if (ioctl.ioctl_wr && (ioctl.ioctl_index == MOD_INDEX)) begin
        mod_id    <= ioctl.ioctl_dout;
        mod_valid <= 1'b1;
      end
      if (ioctl.ioctl_wr && (ioctl.ioctl_index == DIP_INDEX) && (ioctl.ioctl_addr[24:3] == 22'd0)) begin
        dip_sw[{ioctl.ioctl_addr[2:0], 3'b000} +: 8] <= ioctl.ioctl_dout;
      end

      // FSM with registered hold/done outputs
      case (state)
        IDLE: begin
          if (start) state <= LOADING;
        end
        LOADING: begin
          if (!ioctl.ioctl_download) begin
            state     <= DRAIN;
            drain_cnt <= CW'(HOLD_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state           <= DONE;
            core_reset_hold <= 1'b0;
            load_done       <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state           <= LOADING;
            core_reset_hold <= 1'b1;
            load_done       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader_router.sv
module tb_rom_loader_router;

  localparam logic [7:0] ROM_IDX = 8'd0;
  localparam logic [7:0] MOD_IDX = 8'd1;
  localparam logic [7:0] DIP_IDX = 8'd254;
  localparam int         HOLD    = 16;

  // ---------------- clock / reset ----------------
  logic clk_sys;
  logic reset;
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  rom_loader_router_if bus();

  logic [3:0]  rgn_we;
  logic [15:0] rgn_addr;
  logic [7:0]  rgn_data;
  logic [7:0]  mod_id;
  logic        mod_valid;
  logic [63:0] dip_sw;
  logic        core_reset_hold, load_done, load_error;
  logic [24:0] byte_count;
  logic [15:0] checksum;
  logic [1:0]  fsm_state;

  rom_loader_router #(
    .NUM_REGIONS(4), .MAX_AW(16),
    .REGION_BASE({25'h0FF00, 25'h0E000, 25'h08000, 25'h00000}),
    .REGION_AW({5'd16, 5'd12, 5'd12, 5'd15}),
    .ROM_INDEX(ROM_IDX), .MOD_INDEX(MOD_IDX), .DIP_INDEX(DIP_IDX), .HOLD_CYCLES(HOLD)
  ) u_dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl(bus),
    .rgn_we(rgn_we), .rgn_addr(rgn_addr), .rgn_data(rgn_data),
    .mod_id(mod_id), .mod_valid(mod_valid), .dip_sw(dip_sw),
    .core_reset_hold(core_reset_hold), .load_done(load_done), .load_error(load_error),
    .byte_count(byte_count), .checksum(checksum), .fsm_state(fsm_state)
  );

  // Second instance with overlapping windows: r0 0xE000+4K, r1 0x8000+32K,
  // r2 0x0000+32K, r3 0x10000+256. Shares the same stream.
  logic [3:0]  o_we;
  logic [15:0] o_addr;
  logic [7:0]  o_data, o_mod_id;
  logic        o_mod_valid, o_hold, o_done, o_err;
  logic [63:0] o_dip;
  logic [24:0] o_bc;
  logic [15:0] o_cs;
  logic [1:0]  o_state;

  rom_loader_router #(
    .NUM_REGIONS(4), .MAX_AW(16),
    .REGION_BASE({25'h10000, 25'h00000, 25'h08000, 25'h0E000}),
    .REGION_AW({5'd8, 5'd15, 5'd15, 5'd12}),
    .ROM_INDEX(ROM_IDX), .MOD_INDEX(MOD_IDX), .DIP_INDEX(DIP_IDX), .HOLD_CYCLES(HOLD)
  ) u_ovl (
    .clk_sys(clk_sys), .reset(reset), .ioctl(bus),
    .rgn_we(o_we), .rgn_addr(o_addr), .rgn_data(o_data),
    .mod_id(o_mod_id), .mod_valid(o_mod_valid), .dip_sw(o_dip),
    .core_reset_hold(o_hold), .load_done(o_done), .load_error(o_err),
    .byte_count(o_bc), .checksum(o_cs), .fsm_state(o_state)
  );

  // ---------------- reference model + scoreboard ----------------
  // exp_q entry: {we[3:0], addr[15:0], data[7:0]}, one per driven cycle.
  logic [27:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt [4] = '{0, 0, 0, 0};
  int          m_base [4] = '{32'h0, 32'h8000, 32'hE000, 32'hFF00};
  int          m_aw   [4] = '{15, 12, 12, 16};
  int          m_state = 0;
  int          m_cnt = 0;
  logic [24:0] m_bc = '0;
  logic [15:0] m_cs = '0;
  logic        m_err = 1'b0;

  function automatic int decode(input logic [24:0] a);
    for (int i = 0; i < 4; i++)
      if (int'(a) >= m_base[i] && int'(a) < m_base[i] + (1 << m_aw[i])) return i;
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input logic r, input logic dl, input logic wr,
                      input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
    logic start, rom;
    int hit;
    logic [27:0] e;
    @(negedge clk_sys); #1;
    reset = r;
    bus.ioctl_download = dl;
    bus.ioctl_wr = wr;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_index = idx;
    e = '0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_bc = '0; m_cs = '0; m_err = 1'b0;
    end else begin
      start = (m_state == 0 || m_state == 3) && dl && (idx == ROM_IDX);
      rom = wr && (idx == ROM_IDX) && (m_state == 1 || start);
      if (start) begin m_bc = '0; m_cs = '0; m_err = 1'b0; end
      if (rom) begin
        m_bc = m_bc + 25'd1;
        m_cs = m_cs + 16'(d);
        hit = decode(a);
        if (hit >= 0) begin
          e[24 + hit] = 1'b1;
          e[23:8] = 16'(int'(a) - m_base[hit]);
          e[7:0] = d;
        end else m_err = 1'b1;
      end
      case (m_state)
        0, 3: if (start) m_state = 1;
        1: if (!dl) begin m_state = 2; m_cnt = HOLD - 1; end
        2: if (m_cnt == 0) m_state = 3; else m_cnt = m_cnt - 1;
        default: m_state = 0;
      endcase
    end
    exp_q.push_back(e);
    @(posedge clk_sys);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 25'd0, 8'd0, 8'd0);
  endtask

  // Strobe monitor: every driven cycle has one expected entry.
  task automatic monitor_loop();
    logic [27:0] e;
    forever begin
      @(negedge clk_sys);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rgn_we !== e[27:24]) begin
          errors++;
          $display("FAIL strobe_we: got %b want %b", rgn_we, e[27:24]);
        end else if (e[27:24] != 4'd0 && (rgn_addr !== e[23:8] || rgn_data !== e[7:0])) begin
          errors++;
          $display("FAIL strobe_payload: got addr %h data %h want addr %h data %h",
                   rgn_addr, rgn_data, e[23:8], e[7:0]);
        end
        for (int i = 0; i < 4; i++) if (rgn_we[i] === 1'b1) strobe_cnt[i]++;
      end else if ((|rgn_we) === 1'b1) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got %b", rgn_we);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 25'd0, 8'd0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 25'd0, 8'd0, 8'd0);
    #1;
    checks++; if (rgn_we !== 4'd0 || rgn_addr !== 16'd0 || rgn_data !== 8'd0) begin errors++;
      $display("FAIL reset_wpath: got %b %h %h want 0 0 0", rgn_we, rgn_addr, rgn_data); end
    checks++; if (mod_id !== 8'd0 || mod_valid !== 1'b0 || dip_sw !== 64'd0) begin errors++;
      $display("FAIL reset_side: got %h %b %h want 0", mod_id, mod_valid, dip_sw); end
    checks++; if (core_reset_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin errors++;
      $display("FAIL reset_flags: got hold %b done %b err %b want 1 0 0", core_reset_hold, load_done, load_error); end
    checks++; if (byte_count !== 25'd0 || checksum !== 16'd0 || fsm_state !== 2'd0) begin errors++;
      $display("FAIL reset_stats: got %h %h st %0d want 0 0 0", byte_count, checksum, fsm_state); end
    tick(1'b0, 1'b0, 1'b0, 25'd0, 8'd0, 8'd0);
  endtask

  task automatic test_full_stream();
    int snap [4];
    int want [4] = '{32768, 4096, 4096, 256};
    for (int i = 0; i < 4; i++) snap[i] = strobe_cnt[i];
    for (int i = 0; i < 65536; i++) tick(1'b0, 1'b1, 1'b1, 25'(i), 8'(i), ROM_IDX);
    tick(1'b0, 1'b0, 1'b0, 25'd0, 8'd0, ROM_IDX);
    #1;
    checks++; if (byte_count !== 25'h10000) begin errors++;
      $display("FAIL full_count: got %h want 10000", byte_count); end
    checks++; if (checksum !== 16'h8000) begin errors++;
      $display("FAIL full_checksum: got %h want 8000", checksum); end
    // 0x9000-0xDFFF and 0xF000-0xFEFF fall in no window
    checks++; if (load_error !== 1'b1) begin errors++;
      $display("FAIL full_error: got %b want 1", load_error); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (strobe_cnt[i] - snap[i] != want[i]) begin errors++;
        $display("FAIL full_strobes_r%0d: got %0d want %0d", i, strobe_cnt[i] - snap[i], want[i]); end
    end
    checks++; if (fsm_state !== 2'd2 || core_reset_hold !== 1'b1) begin errors++;
      $display("FAIL full_drain: got st %0d hold %b want 2 1", fsm_state, core_reset_hold); end
  endtask

  // Called right after the edge T that sampled the download fall.
  task automatic test_release();
    for (int k = 1; k <= HOLD; k++) begin
      idle_ticks(1);
      #1;
      checks++;
      if (core_reset_hold !== (k < HOLD) || load_done !== (k == HOLD)) begin errors++;
        $display("FAIL release_T+%0d: got hold %b done %b want %b %b", k, core_reset_hold,
                 load_done, k < HOLD, k == HOLD); end
    end
    checks++; if (fsm_state !== 2'd3) begin errors++;
      $display("FAIL release_state: got %0d want 3", fsm_state); end
  endtask

  task automatic test_overlap_miss();
    tick(1'b0, 1'b1, 1'b1, 25'h0E000, 8'h11, ROM_IDX);
    #1;
    checks++; if (o_we !== 4'b0001 || o_addr !== 16'h0000 || o_data !== 8'h11) begin errors++;
      $display("FAIL overlap_low_wins: got %b %h %h want 0001 0000 11", o_we, o_addr, o_data); end
    checks++; if (load_done !== 1'b0 || core_reset_hold !== 1'b1 || load_error !== 1'b0 || byte_count !== 25'd1) begin errors++;
      $display("FAIL restart_clear: got done %b hold %b err %b cnt %h want 0 1 0 1", load_done, core_reset_hold, load_error, byte_count); end
    tick(1'b0, 1'b1, 1'b1, 25'h1FFFF, 8'h22, ROM_IDX);
    #1;
    checks++; if (o_we !== 4'd0 || o_err !== 1'b1 || load_error !== 1'b1) begin errors++;
      $display("FAIL miss: got we %b err %b/%b want 0 1 1", o_we, o_err, load_error); end
    tick(1'b0, 1'b1, 1'b1, 25'h0F000, 8'h33, ROM_IDX);
    #1;
    checks++; if (o_we !== 4'b0010 || o_addr !== 16'h7000) begin errors++;
      $display("FAIL overlap_r1: got %b %h want 0010 7000", o_we, o_addr); end
    tick(1'b0, 1'b1, 1'b0, 25'd0, 8'd0, ROM_IDX);
    tick(1'b0, 1'b0, 1'b0, 25'd0, 8'd0, ROM_IDX);
    idle_ticks(HOLD);
    #1;
    checks++; if (load_error !== 1'b1 || load_done !== 1'b1 || checksum !== m_cs || byte_count !== 25'd3) begin errors++;
      $display("FAIL miss_sticky: got err %b done %b cs %h cnt %h want 1 1 %h 3", load_error, load_done, checksum, byte_count, m_cs); end
  endtask

  task automatic test_mod_dip();
    tick(1'b0, 1'b1, 1'b1, 25'd0, 8'h03, MOD_IDX);
    tick(1'b0, 1'b1, 1'b1, 25'd0, 8'h04, MOD_IDX);
    tick(1'b0, 1'b0, 1'b0, 25'd0, 8'd0, MOD_IDX);
    #1;
    checks++; if (mod_id !== 8'h04 || mod_valid !== 1'b1) begin errors++;
      $display("FAIL mod_last_wins: got %h %b want 04 1", mod_id, mod_valid); end
    tick(1'b0, 1'b1, 1'b1, 25'd2, 8'hA5, DIP_IDX);
    tick(1'b0, 1'b1, 1'b1, 25'd8, 8'h5A, DIP_IDX);
    tick(1'b0, 1'b0, 1'b0, 25'd0, 8'd0, DIP_IDX);
    #1;
    checks++; if (dip_sw !== 64'h0000_0000_00A5_0000) begin errors++;
      $display("FAIL dip_bytes: got %h want 0000000000a50000", dip_sw); end
    checks++; if (fsm_state !== 2'd3 || byte_count !== m_bc || load_done !== 1'b1) begin errors++;
      $display("FAIL side_no_fsm: got st %0d cnt %h done %b want 3 %h 1", fsm_state, byte_count, load_done, m_bc); end
  endtask

  task automatic test_back_to_back();
    int snap0;
    snap0 = strobe_cnt[0];
    // Write present on the rise cycle (i=0) and the fall cycle (i=20)
    for (int i = 0; i <= 20; i++)
      tick(1'b0, (i < 20), 1'b1, 25'(32'h100 + i), 8'($urandom_range(0, 255)), ROM_IDX);
    #1;
    checks++; if (byte_count !== 25'd21 || checksum !== m_cs || load_error !== 1'b0) begin errors++;
      $display("FAIL b2b_stats: got cnt %h cs %h err %b want 15 %h 0", byte_count, checksum, load_error, m_cs); end
    checks++; if (fsm_state !== 2'd2) begin errors++;
      $display("FAIL b2b_fall_state: got %0d want 2", fsm_state); end
    idle_ticks(1);
    checks++; if (strobe_cnt[0] - snap0 != 21) begin errors++;
      $display("FAIL b2b_strobes: got %0d want 21", strobe_cnt[0] - snap0); end
    idle_ticks(HOLD);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 100; i++)
      tick(1'b0, 1'b1, 1'b1, 25'($urandom_range(0, 32'hFFFF)), 8'($urandom_range(0, 255)), ROM_IDX);
    tick(1'b1, 1'b1, 1'b1, 25'h10, 8'h55, ROM_IDX);
    #1;
    checks++; if (rgn_we !== 4'd0 || rgn_addr !== 16'd0 || rgn_data !== 8'd0 || fsm_state !== 2'd0) begin errors++;
      $display("FAIL midreset_wpath: got %b %h %h st %0d want 0 0 0 0", rgn_we, rgn_addr, rgn_data, fsm_state); end
    checks++; if (mod_id !== 8'd0 || mod_valid !== 1'b0 || dip_sw !== 64'd0 || core_reset_hold !== 1'b1) begin errors++;
      $display("FAIL midreset_side: got %h %b %h hold %b want 0 0 0 1", mod_id, mod_valid, dip_sw, core_reset_hold); end
    checks++; if (byte_count !== 25'd0 || checksum !== 16'd0 || load_error !== 1'b0 || load_done !== 1'b0) begin errors++;
      $display("FAIL midreset_stats: got %h %h %b %b want 0 0 0 0", byte_count, checksum, load_error, load_done); end
    idle_ticks(1);
    for (int i = 0; i < 300; i++)
      tick(1'b0, 1'b1, 1'b1, 25'(32'h7F00 + i), 8'($urandom_range(0, 255)), ROM_IDX);
    tick(1'b0, 1'b0, 1'b0, 25'd0, 8'd0, ROM_IDX);
    idle_ticks(HOLD);
    #1;
    checks++; if (byte_count !== 25'd300 || checksum !== m_cs || load_error !== 1'b0) begin errors++;
      $display("FAIL reload_stats: got %h %h %b want 12c %h 0", byte_count, checksum, load_error, m_cs); end
    checks++; if (load_done !== 1'b1 || core_reset_hold !== 1'b0 || fsm_state !== 2'd3) begin errors++;
      $display("FAIL reload_done: got done %b hold %b st %0d want 1 0 3", load_done, core_reset_hold, fsm_state); end
  endtask

  task automatic run_tests();
    test_reset();
    test_full_stream();
    test_release();
    test_overlap_miss();
    test_mod_dip();
    test_back_to_back();
    test_reset_mid();
    idle_ticks(2);
    @(negedge clk_sys); #2;
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.ioctl_index = '0;
    fork
      run_tests();
      monitor_loop();
      begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: time limit reached");
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
